mdu_ctrl: RTL and testbench

MDU_CTRL -- requirements
Module: mdu_ctrl

---
 rtl/mdu_ctrl.sv | 170 +++++++++++++++++
 tb/tb_mdu_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_ctrl.sv
// Multiply/divide unit controller: owns HI/LO, runs single-cycle multiply and a
// 32-cycle restoring divider, and requests pipeline stalls while busy.
module mdu_ctrl (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state_r, state_nx_s;
    logic [1:0]  op_r;
    logic [31:0] a_r, b_r;
    logic [31:0] rem_r, quo_r, div_r;
    logic [4:0]  cnt_r;

    logic        accept_s, div_last_s, wr_s, ge_s;
    logic [32:0] shift_s;
    logic [31:0] rem_nx_s, quo_nx_s, rem_fix_s, quo_fix_s;
    logic [31:0] res_hi_s, res_lo_s;
    logic [63:0] prod_s;

    function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
        if (is_signed && v[31]) begin
            return ~v + 32'd1;
        end else begin
            return v;
        end
    endfunction

    function automatic logic [63:0] ext64(input logic [31:0] v, input logic is_signed);
        return {{32{is_signed & v[31]}}, v};
    endfunction

    assign accept_s   = (state_r == IDLE) & start & ~flush;
    assign div_last_s = (state_r == DIV) & (cnt_r == 5'd31);

    // State register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic; flush overrides everything, including a same-cycle start
    always_comb begin
        state_nx_s = state_r;
        if (flush) begin
            state_nx_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (!start) begin
                        state_nx_s = IDLE;
                    end else if (!op[1]) begin
                        state_nx_s = MUL;
                    end else if (src_b == 32'd0) begin
                        state_nx_s = DONE;
                    end else begin
                        state_nx_s = DIV;
                    end
                end
                MUL:     state_nx_s = DONE;
                DIV:     state_nx_s = (cnt_r == 5'd31) ? DONE : DIV;
                DONE:    state_nx_s = IDLE;
                default: state_nx_s = IDLE;
            endcase
        end
    end

    // FSM outputs
    always_comb begin
        stall = 1'b0;
        done  = 1'b0;
        if (resetn) begin
            stall = accept_s | (state_r == MUL) | (state_r == DIV);
        end else begin
            stall = 1'b0;
        end
        done = (state_r == DONE);
    end

    // One restoring-divide step plus sign correction of the final step
    always_comb begin
        shift_s   = {rem_r, quo_r[31]};
        ge_s      = (shift_s >= {1'b0, div_r});
        rem_nx_s  = ge_s ? (shift_s[31:0] - div_r) : shift_s[31:0];
        quo_nx_s  = {quo_r[30:0], ge_s};
        quo_fix_s = (~op_r[0] & (a_r[31] ^ b_r[31])) ? (~quo_nx_s + 32'd1) : quo_nx_s;
        rem_fix_s = (~op_r[0] & a_r[31]) ? (~rem_nx_s + 32'd1) : rem_nx_s;
        prod_s    = ext64(a_r, ~op_r[0]) * ext64(b_r, ~op_r[0]);
    end

    // Result-write selection for the edge that enters DONE
    always_comb begin
        wr_s     = 1'b0;
        res_hi_s = 32'd0;
        res_lo_s = 32'd0;
        if (accept_s && op[1] && (src_b == 32'd0)) begin
            wr_s     = 1'b1;
            res_hi_s = src_a;
            res_lo_s = 32'hFFFF_FFFF;
        end else if ((state_r == MUL) && !flush) begin
            wr_s     = 1'b1;
            res_hi_s = prod_s[63:32];
            res_lo_s = prod_s[31:0];
        end else if (div_last_s && !flush) begin
            wr_s     = 1'b1;
            res_hi_s = rem_fix_s;
            res_lo_s = quo_fix_s;
        end else begin
            wr_s = 1'b0;
        end
    end

    // Operand latches, divider iteration and HI/LO; the older result beats MTHI/MTLO
    always_ff @(posedge clk) begin
        if (!resetn) begin
            op_r  <= 2'd0;
            a_r   <= 32'd0;
            b_r   <= 32'd0;
            rem_r <= 32'd0;
            quo_r <= 32'd0;
            div_r <= 32'd0;
            cnt_r <= 5'd0;
            hi_o  <= 32'd0;
            lo_o  <= 32'd0;
        end else begin
            if (accept_s) begin
                op_r  <= op;
                a_r   <= src_a;
                b_r   <= src_b;
                rem_r <= 32'd0;
                quo_r <= mag32(src_a, ~op[0]);
                div_r <= mag32(src_b, ~op[0]);
                cnt_r <= 5'd0;
            end else if (state_r == DIV) begin
                rem_r <= rem_nx_s;
                quo_r <= quo_nx_s;
                cnt_r <= div_last_s ? cnt_r : (cnt_r + 5'd1);
            end
            if (wr_s) begin
                hi_o <= res_hi_s;
                lo_o <= res_lo_s;
            end else begin
                if (hi_we) hi_o <= wdata;
                if (lo_we) lo_o <= wdata;
            end
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed corner cases plus random traffic,
// compared every cycle against a latency/arithmetic reference model.
module tb_mdu_ctrl;

    logic        clk = 1'b0;
    logic        resetn, start, flush, hi_we, lo_we;
    logic [1:0]  op;
    logic [31:0] src_a, src_b, wdata;
    logic        stall, done;
    logic [31:0] hi_o, lo_o;

    int checks = 0;
    int errors = 0;

    // reference model state
    bit          m_busy, m_doneph;
    int          m_left;
    logic [63:0] m_pend;
    logic [31:0] m_hi, m_lo;
    logic        obs_done;

    mdu_ctrl dut (
        .clk(clk), .resetn(resetn), .start(start), .op(op),
        .src_a(src_a), .src_b(src_b), .flush(flush),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .stall(stall), .done(done), .hi_o(hi_o), .lo_o(lo_o)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // {HI, LO} from plain integer arithmetic
    function automatic logic [63:0] ref_res(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, q, r;
        longint unsigned ua, ub, uq, ur;
        logic [63:0]     res;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'd0, a};
        ub = {32'd0, b};
        res = 64'd0;
        case (o)
            2'd0: res = sa * sb;
            2'd1: res = ua * ub;
            2'd2: begin
                if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    res = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
                else begin
                    uq = ua / ub;
                    ur = ua % ub;
                    res = {ur[31:0], uq[31:0]};
                end
            end
        endcase
        return res;
    endfunction

    task automatic model_update();
        bit wr;
        int lat;
        wr = 1'b0;
        if (!resetn) begin
            m_busy = 1'b0; m_doneph = 1'b0; m_hi = 32'd0; m_lo = 32'd0;
        end else begin
            if (flush) begin
                m_busy = 1'b0; m_doneph = 1'b0;
            end else if (m_doneph) begin
                m_doneph = 1'b0;
            end else if (m_busy) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 1'b0; m_doneph = 1'b1; wr = 1'b1;
                end
            end else if (start) begin
                m_pend = ref_res(op, src_a, src_b);
                lat = !op[1] ? 2 : ((src_b == 32'd0) ? 1 : 33);
                if (lat == 1) begin
                    m_doneph = 1'b1; wr = 1'b1;
                end else begin
                    m_busy = 1'b1; m_left = lat - 1;
                end
            end
            if (wr) begin
                m_hi = m_pend[63:32];
                m_lo = m_pend[31:0];
            end else begin
                if (hi_we) m_hi = wdata;
                if (lo_we) m_lo = wdata;
            end
        end
    endtask

    // one clock: compare on the falling edge, advance the model on the rising edge
    task automatic cycle();
        logic exp_stall;
        @(negedge clk);
        exp_stall = resetn && (m_busy || (!m_doneph && start && !flush));
        obs_done = done;
        chk("stall", {31'd0, stall}, {31'd0, exp_stall});
        chk("done", {31'd0, done}, {31'd0, m_doneph});
        chk("hi", hi_o, m_hi);
        chk("lo", lo_o, m_lo);
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle_inputs();
        start = 1'b0; flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0; resetn = 1'b1;
    endtask

    // abort_kind: 0 none, 1 flush, 2 reset
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int abort_kind, input int abort_at, input int we_at,
                          output int done_cyc);
        done_cyc = -1;
        for (int k = 0; k < 45; k++) begin
            start  = (k == 0) || m_busy;
            op     = o;
            src_a  = a;
            src_b  = b;
            flush  = (abort_kind == 1) && (k == abort_at);
            resetn = !((abort_kind == 2) && (k == abort_at));
            hi_we  = (k == we_at);
            lo_we  = 1'b0;
            wdata  = 32'h1234_5678;
            cycle();
            if (obs_done && done_cyc < 0) done_cyc = k;
            if (abort_kind != 0 && k >= abort_at + 2) break;
            if (done_cyc >= 0 && k > done_cyc) break;
        end
        idle_inputs();
    endtask

    task automatic pin(input string tag, input logic [31:0] eh, input logic [31:0] el);
        chk({tag, "_hi"}, hi_o, eh);
        chk({tag, "_lo"}, lo_o, el);
        chk({tag, "_model_hi"}, m_hi, eh);
        chk({tag, "_model_lo"}, m_lo, el);
    endtask

    initial begin
        int lat;
        int r;
        m_busy = 1'b0; m_doneph = 1'b0; m_left = 0; m_pend = 64'd0;
        m_hi = 32'd0; m_lo = 32'd0;
        op = 2'd0; src_a = 32'd0; src_b = 32'd0; wdata = 32'd0;
        idle_inputs();
        resetn = 1'b0;
        repeat (3) cycle();
        resetn = 1'b1;
        cycle();
        pin("reset", 32'd0, 32'd0);

        run_op(2'd0, 32'hFFFF_FFFF, 32'd2, 0, 0, -1, lat);
        chk("mult_latency", lat, 32'd2);
        pin("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFE);

        run_op(2'd1, 32'hFFFF_FFFF, 32'd2, 0, 0, -1, lat);
        chk("multu_latency", lat, 32'd2);
        pin("multu", 32'h0000_0001, 32'hFFFF_FFFE);

        run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 0, 0, -1, lat);
        chk("div_latency", lat, 32'd33);
        pin("div_neg7_2", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, -1, lat);
        chk("div_wrap_latency", lat, 32'd33);
        pin("div_wrap", 32'h0000_0000, 32'h8000_0000);

        run_op(2'd3, 32'd100, 32'd0, 0, 0, -1, lat);
        chk("divz_latency", lat, 32'd1);
        pin("divz", 32'h0000_0064, 32'hFFFF_FFFF);

        run_op(2'd3, 32'd1000, 32'd7, 1, 10, -1, lat);
        chk("flush_no_done", lat, 32'hFFFF_FFFF);
        pin("flush_keep", 32'h0000_0064, 32'hFFFF_FFFF);

        run_op(2'd3, 32'd1000, 32'd7, 2, 10, -1, lat);
        chk("reset_no_done", lat, 32'hFFFF_FFFF);
        pin("reset_abort", 32'd0, 32'd0);

        run_op(2'd0, 32'hFFFF_FFFF, 32'd2, 0, 0, 1, lat);
        pin("collision", 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        hi_we = 1'b1;
        wdata = 32'h1234_5678;
        cycle();
        idle_inputs();
        cycle();
        pin("mthi", 32'h1234_5678, 32'hFFFF_FFFE);

        for (int i = 0; i < 1500; i++) begin
            resetn = ($urandom_range(0, 199) != 0);
            start  = ($urandom_range(0, 2) == 0);
            op     = 2'($urandom_range(0, 3));
            src_a  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            r      = $urandom_range(0, 7);
            if (r == 0)      src_b = 32'd0;
            else if (r == 1) src_b = 32'hFFFF_FFFF;
            else if (r == 2) src_b = 32'($urandom_range(1, 15));
            else             src_b = $urandom;
            flush  = ($urandom_range(0, 59) == 0);
            hi_we  = ($urandom_range(0, 3) == 0);
            lo_we  = ($urandom_range(0, 3) == 0);
            wdata  = $urandom;
            cycle();
        end
        idle_inputs();
        repeat (40) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
